// File: rtl/serial_wb_pkg.sv
// Shared definitions for the byte-stream to Wishbone master bridge:
// FSM state encoding, command opcodes and response status codes.
package serial_wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_STAT,
        S_RDATA
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'hA1;
    localparam logic [7:0] CMD_WRITE  = 8'hA2;

    localparam logic [7:0] ST_ACK     = 8'h00;
    localparam logic [7:0] ST_ERR     = 8'h01;
    localparam logic [7:0] ST_RTY     = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

endpackage

// File: rtl/serial_wb_master.sv
// Byte-stream to Wishbone master bridge. Parses read/write packets from a
// UART receiver, runs one single-beat Wishbone classic cycle per packet and
// returns a status byte (plus read data on an acked read) to the transmitter.
// Optional feature: define SERIAL_WB_TIMEOUT_EN to abort bus cycles that are
// not terminated within TIMEOUT_CYCLES clocks (status 0x03).
module serial_wb_master
    import serial_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic                    wbm_we_o,
    output logic [SELECT_WIDTH-1:0] wbm_sel_o,
    output logic                    wbm_stb_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    output logic                    wbm_cyc_o,
    output logic                    busy
);

    localparam int ABYTES = ADDR_WIDTH / 8;
    localparam int DBYTES = DATA_WIDTH / 8;
    localparam int MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
    localparam int CNT_W  = $clog2(MAXB + 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    is_write_q, is_write_d;
    logic [7:0]              status_q, status_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    busy_q, busy_d;

    logic                    rx_fire;
    logic                    tx_fire;
    logic                    bus_done;
    logic [7:0]              bus_status;

`ifdef SERIAL_WB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
`else
    // Timeout length only matters when the abort counter is built.
    logic                    unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign rx_fire = rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & tx_ready;

    // Next-state logic: packet parsing, bus cycle control and response sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        is_write_d = is_write_q;
        status_d   = status_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        bus_done   = 1'b0;
        bus_status = ST_ACK;
`ifdef SERIAL_WB_TIMEOUT_EN
        to_cnt_d   = '0;
`endif

        case (state_q)
            S_IDLE: begin
                // Unknown opcodes are swallowed here without a response.
                if (rx_fire && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
                    is_write_d = (rx_data == CMD_WRITE);
                    cnt_d      = '0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d = ADDR_WIDTH'({adr_q, rx_data});
                    if (cnt_q == CNT_W'(ABYTES - 1)) begin
                        cnt_d = '0;
                        if (is_write_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_BUS;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                            sel_d   = '1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (rx_fire) begin
                    wdat_d = DATA_WIDTH'({wdat_q, rx_data});
                    if (cnt_q == CNT_W'(DBYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        sel_d   = '1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BUS: begin
                // err beats rty beats ack when several arrive together.
                if (cyc_q && (wbm_err_i || wbm_rty_i || wbm_ack_i)) begin
                    bus_done = 1'b1;
                    if (wbm_err_i) begin
                        bus_status = ST_ERR;
                    end else if (wbm_rty_i) begin
                        bus_status = ST_RTY;
                    end else begin
                        bus_status = ST_ACK;
                        if (!is_write_q) begin
                            rdat_d = wbm_dat_i;
                        end
                    end
                end
`ifdef SERIAL_WB_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_done   = 1'b1;
                    bus_status = ST_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
                if (bus_done) begin
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = '0;
                    status_d   = bus_status;
                    tx_data_d  = bus_status;
                    tx_valid_d = 1'b1;
                    state_d    = S_STAT;
                end
            end
            S_STAT: begin
                if (tx_fire) begin
                    if (!is_write_q && status_q == ST_ACK) begin
                        tx_data_d = rdat_q[DATA_WIDTH-1 -: 8];
                        rdat_d    = rdat_q << 8;
                        cnt_d     = '0;
                        state_d   = S_RDATA;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_RDATA: begin
                if (tx_fire) begin
                    if (cnt_q == CNT_W'(DBYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = rdat_q[DATA_WIDTH-1 -: 8];
                        rdat_d    = rdat_q << 8;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
        busy_d     = (state_d != S_IDLE);
    end

    // State and registered outputs; active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            is_write_q <= 1'b0;
            status_q   <= ST_ACK;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SERIAL_WB_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            is_write_q <= is_write_d;
            status_q   <= status_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
`ifdef SERIAL_WB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_wb_master.sv
// Directed bench for serial_wb_master: drives command packets, plays the
// Wishbone slave, and scores transmitted bytes against an expected-byte queue.
// Exercises the SERIAL_WB_TIMEOUT_EN path when that macro is defined.
module tb_serial_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        wbm_rty_i = 1'b0;
    logic        wbm_cyc_o;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sb[$];
    logic [7:0] pkt[$];

    serial_wb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .SELECT_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .wbm_cyc_o(wbm_cyc_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_accept_timeout", 64'(t), 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] p[$]);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic check_bus(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        check("cyc_start", 64'(wbm_cyc_o), 64'd1);
        check("stb_start", 64'(wbm_stb_o), 64'd1);
        check("bus_adr", 64'(wbm_adr_o), 64'(adr));
        check("bus_we", 64'(wbm_we_o), 64'(we));
        check("bus_sel", 64'(wbm_sel_o), 64'hF);
        if (we) check("bus_dat_o", 64'(wbm_dat_o), 64'(dat));
    endtask

    task automatic respond(input int waits, input logic a, input logic e, input logic r,
                           input logic [31:0] d);
        for (int i = 0; i < waits; i++) begin
            check("cyc_hold", 64'(wbm_cyc_o), 64'd1);
            @(negedge clk);
        end
        wbm_ack_i = a; wbm_err_i = e; wbm_rty_i = r; wbm_dat_i = d;
        @(negedge clk);
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = 32'h0;
        check("cyc_drop", 64'(wbm_cyc_o), 64'd0);
        check("tx_valid_latency", 64'(tx_valid), 64'd1);
    endtask

    // Drain the scoreboard; each accepted tx byte pops one expected byte.
    task automatic recv(input bit toggle);
        int t = 0;
        logic [7:0] exp;
        while (sb.size() > 0 && t < 200) begin
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (tx_valid && tx_ready) begin
                exp = sb.pop_front();
                check("tx_byte", 64'(tx_data), 64'(exp));
            end
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("tx_timeout", 64'(sb.size()), 64'd0);
        tx_ready = 1'b1;
        check("tx_done", 64'(tx_valid), 64'd0);
        check("idle_after", 64'(busy), 64'd0);
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check(tag, 64'(tx_valid), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        check("rst_stb", 64'(wbm_stb_o), 64'd0);
        check("rst_we", 64'(wbm_we_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sel", 64'(wbm_sel_o), 64'd0);
        check("rst_adr", 64'(wbm_adr_o), 64'd0);
        check("rst_dat", 64'(wbm_dat_o), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Read, ack with DEADBEEF on the 3rd bus cycle.
        pkt = '{8'hA1, 8'h00, 8'h00, 8'h10, 8'h04};
        send_pkt(pkt);
        check_bus(32'h0000_1004, 1'b0, 32'h0);
        sb.push_back(8'h00); sb.push_back(8'hDE); sb.push_back(8'hAD);
        sb.push_back(8'hBE); sb.push_back(8'hEF);
        respond(2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        recv(1'b0);

        // Write, status byte only.
        pkt = '{8'hA2, 8'h00, 8'h00, 8'h20, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        send_pkt(pkt);
        check_bus(32'h0000_2000, 1'b1, 32'h1234_5678);
        sb.push_back(8'h00);
        respond(0, 1'b1, 1'b0, 1'b0, 32'h0);
        recv(1'b0);

        // err and ack together on a read: err wins, no data bytes.
        pkt = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h08};
        send_pkt(pkt);
        check_bus(32'h0000_0008, 1'b0, 32'h0);
        sb.push_back(8'h01);
        respond(1, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
        recv(1'b0);

        // rty and ack together: rty wins.
        pkt = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h0C};
        send_pkt(pkt);
        sb.push_back(8'h02);
        respond(0, 1'b1, 1'b0, 1'b1, 32'h1111_2222);
        recv(1'b0);

        // Unknown byte dropped, then a read with tx backpressure.
        send_byte(8'h55);
        check("drop_busy", 64'(busy), 64'd0);
        quiet(3, "drop_no_tx");
        pkt = '{8'hA1, 8'h00, 8'h00, 8'h30, 8'h10};
        send_pkt(pkt);
        check_bus(32'h0000_3010, 1'b0, 32'h0);
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h23);
        sb.push_back(8'h45); sb.push_back(8'h67);
        respond(0, 1'b1, 1'b0, 1'b0, 32'h0123_4567);
        recv(1'b1);

        // Termination seen while idle is ignored.
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        check("stray_cyc", 64'(wbm_cyc_o), 64'd0);
        quiet(3, "stray_no_tx");

        // Reset mid-address, then a write completes normally.
        pkt = '{8'hA1, 8'h00, 8'h00};
        send_pkt(pkt);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        check("midrst_adr", 64'(wbm_adr_o), 64'd0);
        rst = 1'b1;
        pkt = '{8'hA2, 8'h00, 8'h00, 8'h40, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        send_pkt(pkt);
        check_bus(32'h0000_4004, 1'b1, 32'hA55A_C33C);
        sb.push_back(8'h00);
        respond(3, 1'b1, 1'b0, 1'b0, 32'h0);
        recv(1'b0);

`ifdef SERIAL_WB_TIMEOUT_EN
        // Silent slave: cycle aborts after 16 bus cycles with status 03.
        pkt = '{8'hA1, 8'h00, 8'h00, 8'h50, 8'h00};
        send_pkt(pkt);
        for (int i = 0; i < 16; i++) begin
            check("to_cyc_hold", 64'(wbm_cyc_o), 64'd1);
            @(negedge clk);
        end
        check("to_cyc_drop", 64'(wbm_cyc_o), 64'd0);
        check("to_tx_valid", 64'(tx_valid), 64'd1);
        sb.push_back(8'h03);
        recv(1'b0);
`else
        // Without the timeout the cycle waits as long as the slave does.
        pkt = '{8'hA1, 8'h00, 8'h00, 8'h50, 8'h00};
        send_pkt(pkt);
        sb.push_back(8'h00); sb.push_back(8'h89); sb.push_back(8'hAB);
        sb.push_back(8'hCD); sb.push_back(8'hEF);
        respond(40, 1'b1, 1'b0, 1'b0, 32'h89AB_CDEF);
        recv(1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_wb_master.md
# serial_wb_master

Byte-stream to Wishbone master bridge. It parses read/write command packets arriving from the UART receiver, runs one single-beat Wishbone classic cycle per packet, and returns a status byte (plus read data) to the UART transmitter. Its Wishbone master port drives the master side of the Wishbone address-decode multiplexer, which fans out to the peripherals.

## Interface
- `ADDR_WIDTH`, 32: address width in bits; multiple of 8.
- `DATA_WIDTH`, 32: data width in bits; multiple of 8.
- `SELECT_WIDTH`, DATA_WIDTH/8: byte-select width.
- `TIMEOUT_CYCLES`, 1024: bus cycles before abort; only used with the timeout feature.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  command byte from the UART receiver.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  block accepts `rx_data` this cycle.
- `tx_data`  out  8  response byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts `tx_data`.
- `wbm_adr_o`  out  ADDR_WIDTH  Wishbone address.
- `wbm_dat_o`  out  DATA_WIDTH  Wishbone write data.
- `wbm_dat_i`  in  DATA_WIDTH  Wishbone read data.
- `wbm_we_o`  out  1  write enable.
- `wbm_sel_o`  out  SELECT_WIDTH  byte select; all ones during a cycle.
- `wbm_stb_o`  out  1  strobe.
- `wbm_ack_i`  in  1  acknowledge.
- `wbm_err_i`  in  1  error.
- `wbm_rty_i`  in  1  retry.
- `wbm_cyc_o`  out  1  cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
**Packet format (multi-byte fields are MSB first)**
- Read: `0xA1`, then ADDR_WIDTH/8 address bytes.
- Write: `0xA2`, then address bytes, then DATA_WIDTH/8 data bytes.
- Any other byte received in IDLE is consumed and dropped; no response is sent.

**Response**
- Status byte first: `0x00` ack, `0x01` err, `0x02` rty, `0x03` timeout.
- After a read that ends in ack, DATA_WIDTH/8 data bytes follow, MSB first.
- A write, or any non-ack outcome, returns the status byte only.

**FSM**
- IDLE -> ADDR on a valid command byte.
- ADDR -> WDATA after the last address byte, for a write.
- ADDR -> BUS after the last address byte, for a read.
- WDATA -> BUS after the last data byte.
- BUS -> STAT on termination.
- STAT -> RDATA for a read that ended in ack; otherwise STAT -> IDLE.
- RDATA -> IDLE after the last byte is sent.
- A byte counter sized for max(ADDR_WIDTH, DATA_WIDTH)/8 shifts bytes into the address and write-data registers.

**Termination priority**
- If more than one of `wbm_err_i`, `wbm_rty_i`, `wbm_ack_i` is high in the same cycle: err > rty > ack.
- `wbm_dat_i` is captured only on an ack-terminated read.

**Reset values**
- `rx_ready`, `tx_valid`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `busy` = 0.
- `wbm_sel_o`, `wbm_adr_o`, `wbm_dat_o`, `tx_data` = 0.
- FSM = IDLE.

## Timing
- `rx_ready` = 1 in IDLE, ADDR and WDATA; 0 otherwise. One byte is accepted per cycle when `rx_valid & rx_ready`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` and `wbm_sel_o` assert on the cycle after the last packet byte is accepted.
- They stay asserted, with address and data stable, until a termination input is sampled high.
- They deassert on the next edge; every bus cycle is exactly one beat.
- `tx_valid` asserts on the cycle after termination. Each byte holds until `tx_ready`, and the next byte is presented on the following cycle.
- Minimum latency: 1 cycle from the last rx byte to `cyc`, then 1 cycle from termination to `tx_valid`.
- A termination input seen while `wbm_cyc_o` = 0 is ignored.
- Reset asserted mid-packet or mid-cycle: all outputs return to their reset values at that edge. The partial packet is discarded and nothing is transmitted.

## Configuration
- Macro `SERIAL_WB_TIMEOUT_EN`.
- Defined: a counter runs in BUS. After TIMEOUT_CYCLES cycles with no termination, the block drops `cyc`/`stb` and sends status `0x03`.
- Undefined: no counter is built, and BUS waits indefinitely. Status `0x03` is never produced.

## Structure
- Shared package `serial_wb_pkg` holds:
  - the FSM state enum;
  - command constants `CMD_READ` = 8'hA1 and `CMD_WRITE` = 8'hA2;
  - status constants `ST_ACK`, `ST_ERR`, `ST_RTY`, `ST_TIMEOUT`.
- No sub-module; the block is a single FSM with shift registers.

## Test plan
- Read: rx `A1 00 00 10 04`; slave acks with `DEADBEEF` on the 3rd cycle -> `adr` = 0x00001004, `we` = 0; tx `00 DE AD BE EF`.
- Write: rx `A2 00 00 20 00 12 34 56 78`; slave acks -> `adr` = 0x00002000, `dat_o` = 0x12345678, `we` = 1, `sel` = 4'hF; tx `00`.
- Err and ack high together on a read -> tx `01` only, with no data bytes.
- Unknown byte `0x55`, then a valid read -> `0x55` is dropped with no tx, and the read completes normally.
- With `SERIAL_WB_TIMEOUT_EN` and TIMEOUT_CYCLES = 16, the slave never responds -> `cyc` drops after 16 cycles and tx is `03`.
- Backpressure and reset:
  - `tx_ready` toggled every other cycle during a read response -> all 5 bytes arrive in order.
  - Reset mid-address -> idle; the next packet completes correctly.
